// File: rtl/ram_refresh_arb.sv
// CAS-before-RAS refresh arbiter: performs one DRAM refresh per refresh period,
// opportunistically while the FSB is idle and forced by stalling RAM once urgent.
module ram_refresh_arb #(
    parameter int unsigned CBR_CYC = 1,
    parameter int unsigned RAS_CYC = 3,
    parameter int unsigned PRE_CYC = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic RefReq,
    input  logic RefUrg,
    input  logic BACT,
    input  logic RAMBusy,
    output logic RAMStall,
    output logic RefActive,
    output logic nRASref,
    output logic nCASref,
    output logic RefDone,
    output logic RefMiss
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CBR  = 2'd1,
        RAS  = 2'd2,
        PRE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             start;
    logic             last_pre;
    logic             req_q;

    // BACT is ignored once the period is urgent; a CPU access in progress is never aborted
    assign start = RefReq && !RefDone && !RAMBusy && (!BACT || RefUrg);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_pre   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CBR;
                    cnt_next   = CNT_W'(CBR_CYC - 1);
                end
            end
            CBR: begin
                if (cnt == '0) begin
                    state_next = RAS;
                    cnt_next   = CNT_W'(RAS_CYC - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RAS: begin
                if (cnt == '0) begin
                    state_next = PRE;
                    cnt_next   = CNT_W'(PRE_CYC - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            PRE: begin
                if (cnt == '0) begin
                    last_pre   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes and status are registered from the next state so they align with it
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= 1'b0;
            RAMStall  <= 1'b0;
            RefActive <= 1'b0;
            nRASref   <= 1'b1;
            nCASref   <= 1'b1;
            RefDone   <= 1'b0;
            RefMiss   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            req_q     <= RefReq;
            RefActive <= (state_next != IDLE);
            nCASref   <= !((state_next == CBR) || (state_next == RAS));
            nRASref   <= (state_next != RAS);
            RAMStall  <= (state_next != IDLE) || (RefUrg && RefReq && !RefDone);
            RefMiss   <= req_q && !RefReq && !RefDone && (state == IDLE);
            // A refresh finishing after RefReq dropped does not count for the new period
            if (last_pre) begin
                RefDone <= RefReq;
            end else if (!RefReq) begin
                RefDone <= 1'b0;
            end
        end
    end

endmodule
